trb_capture_ctrl: RTL and testbench

- Capture controller for the Data Trace Buffer; sits directly upstream of the trace BRAM.
- Consumes the `config_t` configuration and a data/trigger stream, and writes trace words circularly into the BRAM.
- Detects the trigger, then applies the post-trigger delay window and stops.
- Produces the `status_t` record consumed by the readout side.

---
 rtl/trb_capture_ctrl_pkg.sv | 41 ++++
 rtl/trb_capture_ctrl_prio_enc.sv | 29 ++
 rtl/trb_capture_ctrl.sv | 158 +++++++++++++++
 tb/tb_trb_capture_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trb_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trb_capture_ctrl_pkg
//   Shared types and constants for the Data Trace Buffer capture path.
//   Provides the trigger configuration record (config_t), the trigger status
//   record (status_t), their default values, the capture FSM state type and
//   the derived geometry constants of the trace BRAM.
// -----------------------------------------------------------------------------
package trb_capture_ctrl_pkg;

  localparam int unsigned TRB_WIDTH     = 32;
  localparam int unsigned TRB_DEPTH     = 32;
  localparam int unsigned TRB_POST_STEP = TRB_DEPTH / 4;
  localparam int unsigned TRB_PTR_WIDTH = $clog2(TRB_DEPTH);
  localparam int unsigned TRB_POS_WIDTH = $clog2(TRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // trg_mode:       0 = single shot, 1 = re-arm after each capture window
  // trg_num_traces: number of qualifying hits to skip before firing
  // trg_delay:      post-trigger window in units of TRB_POST_STEP words
  typedef struct packed {
    logic       trg_mode;
    logic [1:0] trg_num_traces;
    logic [1:0] trg_delay;
  } config_t;

  typedef struct packed {
    logic                     trg_event;
    logic [TRB_POS_WIDTH-1:0] event_pos;
    logic [TRB_PTR_WIDTH-1:0] event_addr;
  } status_t;

  localparam config_t CONFIG_DEFAULT = '0;
  localparam status_t STATUS_DEFAULT = '0;

endpackage

// File: rtl/trb_capture_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// trb_prio_enc
//   Combinational lowest-set-bit encoder.
//   Ports:
//     req_i   [WIDTH]  request vector
//     idx_o   [IDX_W]  index of the lowest set bit of req_i (0 when none)
//     valid_o          at least one bit of req_i is set
// -----------------------------------------------------------------------------
module trb_prio_enc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req_i[i] && !valid_o) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// trb_capture_ctrl
//   Capture controller for the Data Trace Buffer. Writes the incoming trace
//   stream circularly into the trace BRAM, detects the configured trigger,
//   runs the post-trigger window and then stops (or re-arms in mode 1).
//   Ports:
//     clk_i, rst_ni         clock, asynchronous active-low reset
//     conf_i                trigger configuration (config_t)
//     conf_update_i         latch conf_i, clear pointer/counters and (re)arm
//     data_i, data_valid_i  trace word and its qualifier
//     trigger_i             per-bit trigger hits qualifying data_i
//     bram_we_o/addr_o/data_o  registered BRAM write port
//     status_o              registered trigger status (status_t)
//     done_o                capture window complete
// -----------------------------------------------------------------------------
module trb_capture_ctrl
  import trb_capture_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = TRB_WIDTH,
  parameter int unsigned DEPTH = TRB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  config_t                  conf_i,
  input  logic                     conf_update_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     data_valid_i,
  input  logic [WIDTH-1:0]         trigger_i,
  output logic                     bram_we_o,
  output logic [$clog2(DEPTH)-1:0] bram_addr_o,
  output logic [WIDTH-1:0]         bram_data_o,
  output status_t                  status_o,
  output logic                     done_o
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned POS_W     = $clog2(WIDTH);
  localparam int unsigned POST_STEP = DEPTH / 4;

  ctrl_state_t      state_q;
  config_t          conf_q;
  logic [PTR_W-1:0] ptr_q;
  logic [1:0]       hit_cnt_q;
  logic [PTR_W-1:0] post_cnt_q;
  status_t          status_q;
  logic             done_q;
  logic             we_q;
  logic [PTR_W-1:0] addr_q;
  logic [WIDTH-1:0] data_q;

  logic [POS_W-1:0] trg_pos;
  logic             trg_any;
  logic             hit;
  logic [PTR_W-1:0] post_load;

  trb_prio_enc #(
    .WIDTH (WIDTH),
    .IDX_W (POS_W)
  ) u_prio_enc (
    .req_i   (trigger_i),
    .idx_o   (trg_pos),
    .valid_o (trg_any)
  );

  assign hit       = data_valid_i && trg_any;
  // trg_delay * DEPTH/4 is at most 3*DEPTH/4, so it always fits the pointer width.
  assign post_load = PTR_W'(32'(conf_q.trg_delay) * POST_STEP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      conf_q     <= CONFIG_DEFAULT;
      ptr_q      <= '0;
      hit_cnt_q  <= '0;
      post_cnt_q <= '0;
      status_q   <= STATUS_DEFAULT;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (conf_update_i) begin
        // Re-arm from any state; a word presented alongside the update is dropped.
        conf_q     <= conf_i;
        ptr_q      <= '0;
        hit_cnt_q  <= '0;
        post_cnt_q <= '0;
        status_q   <= STATUS_DEFAULT;
        done_q     <= 1'b0;
        state_q    <= ARMED;
      end else begin
        unique case (state_q)
          IDLE: begin
          end

          ARMED: begin
            if (data_valid_i) begin
              we_q   <= 1'b1;
              addr_q <= ptr_q;
              data_q <= data_i;
              ptr_q  <= ptr_q + 1'b1;
              if (hit) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
                // hit_cnt_q counts earlier hits, so equality means hit number num+1.
                if (hit_cnt_q == conf_q.trg_num_traces) begin
                  status_q.trg_event  <= 1'b1;
                  status_q.event_pos  <= TRB_POS_WIDTH'(trg_pos);
                  status_q.event_addr <= TRB_PTR_WIDTH'(ptr_q);
                  post_cnt_q          <= post_load;
                  if (post_load == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                  end else begin
                    state_q <= POST;
                  end
                end
              end
            end
          end

          POST: begin
            if (data_valid_i) begin
              we_q       <= 1'b1;
              addr_q     <= ptr_q;
              data_q     <= data_i;
              ptr_q      <= ptr_q + 1'b1;
              post_cnt_q <= post_cnt_q - 1'b1;
              if (post_cnt_q == PTR_W'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end

          DONE: begin
            if (conf_q.trg_mode) begin
              // done_q was raised on entry, so it is high for exactly this one cycle.
              state_q   <= ARMED;
              done_q    <= 1'b0;
              status_q  <= STATUS_DEFAULT;
              hit_cnt_q <= '0;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bram_we_o   = we_q;
  assign bram_addr_o = addr_q;
  assign bram_data_o = data_q;
  assign status_o    = status_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_trb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trb_capture_ctrl
//   Self-checking bench for trb_capture_ctrl (WIDTH=32, DEPTH=32).
//   Expected BRAM writes are queued when a word is driven and popped by a
//   monitor whenever the DUT writes; status/done are checked inline per test.
// -----------------------------------------------------------------------------
module tb_trb_capture_ctrl;
  import trb_capture_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  config_t     conf_i;
  logic        conf_update_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic [31:0] trigger_i;
  logic        bram_we_o;
  logic [4:0]  bram_addr_o;
  logic [31:0] bram_data_o;
  status_t     status_o;
  logic        done_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  trb_capture_ctrl #(
    .WIDTH (32),
    .DEPTH (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .conf_i        (conf_i),
    .conf_update_i (conf_update_i),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .trigger_i     (trigger_i),
    .bram_we_o     (bram_we_o),
    .bram_addr_o   (bram_addr_o),
    .bram_data_o   (bram_data_o),
    .status_o      (status_o),
    .done_o        (done_o)
  );

  // Scoreboard: every BRAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bram_we_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bram_write unexpected: addr=%0d data=%h, required no write", bram_addr_o, bram_data_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bram_addr_o !== e.addr || bram_data_o !== e.data) begin
          miscompares++;
          $display("FAIL bram_write got addr=%0d data=%h, required addr=%0d data=%h",
                   bram_addr_o, bram_data_o, e.addr, e.data);
        end
      end
    end else if (bram_we_o !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL bram_we got %b, required 0 or 1", bram_we_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one valid word; queue an expected write when one is required.
  task automatic put(input logic [31:0] d, input logic [31:0] t,
                     input bit expect_wr, input logic [4:0] addr);
    wr_t e;
    data_i       = d;
    trigger_i    = t;
    data_valid_i = 1'b1;
    if (expect_wr) begin
      e.addr = addr;
      e.data = d;
      exp_q.push_back(e);
    end
    tick();
    data_valid_i = 1'b0;
    trigger_i    = '0;
  endtask

  task automatic do_config(input logic mode, input logic [1:0] num, input logic [1:0] delay);
    conf_i.trg_mode       = mode;
    conf_i.trg_num_traces = num;
    conf_i.trg_delay      = delay;
    conf_update_i         = 1'b1;
    data_valid_i          = 1'b1;
    data_i                = $urandom;
    trigger_i             = '1;
    tick();
    conf_update_i = 1'b0;
    data_valid_i  = 1'b0;
    trigger_i     = '0;
    vectors++;
    if (status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL config_clear got status=%h done=%b, required status=%h done=0",
               status_o, done_o, STATUS_DEFAULT);
    end
  endtask

  function automatic status_t mk_status(input logic [4:0] pos, input logic [4:0] addr);
    status_t s;
    s.trg_event  = 1'b1;
    s.event_pos  = pos;
    s.event_addr = addr;
    return s;
  endfunction

  task automatic test_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_writes_missing got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (bram_we_o !== 1'b0 || bram_addr_o !== 5'd0 || bram_data_o !== 32'd0 ||
        status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got we=%b addr=%0d data=%h status=%h done=%b, required all 0",
               bram_we_o, bram_addr_o, bram_data_o, status_o, done_o);
    end
    @(negedge clk);
    data_valid_i = 1'b1;
    trigger_i    = 32'hFFFF_FFFF;
    rst_n        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_i = $urandom;
      tick();
      vectors++;
      if (bram_we_o !== 1'b0 || status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d got we=%b status=%h done=%b, required we=0 status=%h done=0",
                 i, bram_we_o, status_o, done_o, STATUS_DEFAULT);
      end
    end
    data_valid_i = 1'b0;
    trigger_i    = '0;
    test_drained("reset");
  endtask

  task automatic test_single_shot();
    do_config(1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      put($urandom, (i == 2) ? 32'h8000_0010 : 32'h0, i <= 2, 5'(i));
      if (i >= 2) begin
        vectors++;
        if (status_o !== mk_status(5'd4, 5'd2) || done_o !== 1'b1) begin
          miscompares++;
          $display("FAIL single_shot_w%0d got status=%h done=%b, required status=%h done=1",
                   i, status_o, done_o, mk_status(5'd4, 5'd2));
        end
      end
    end
    test_drained("single_shot");
  endtask

  task automatic test_post_wrap();
    do_config(1'b0, 2'd0, 2'd2);
    for (int i = 0; i < 20; i++) put($urandom, 32'h0, 1'b1, 5'(i));
    put($urandom, 32'h0000_0100, 1'b1, 5'd20);
    vectors++;
    if (status_o !== mk_status(5'd8, 5'd20) || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_fire got status=%h done=%b, required status=%h done=0",
               status_o, done_o, mk_status(5'd8, 5'd20));
    end
    for (int k = 0; k < 16; k++) begin
      put($urandom, $urandom | 32'h1, 1'b1, 5'(21 + k));
      if (k == 14 || k == 15) begin
        vectors++;
        if (done_o !== (k == 15) || status_o !== mk_status(5'd8, 5'd20)) begin
          miscompares++;
          $display("FAIL post_k%0d got done=%b status=%h, required done=%0d status=%h",
                   k, done_o, status_o, (k == 15), mk_status(5'd8, 5'd20));
        end
      end
    end
    for (int j = 0; j < 3; j++) put($urandom, 32'h1, 1'b0, 5'd0);
    vectors++;
    if (done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL post_done_hold got done=%b, required 1", done_o);
    end
    test_drained("post_wrap");
  endtask

  task automatic test_hit_count();
    do_config(1'b0, 2'd2, 2'd0);
    for (int i = 0; i < 12; i++) begin
      put($urandom, (i == 1 || i == 5) ? 32'h1 : (i == 9) ? 32'h6 : 32'h0, i <= 9, 5'(i));
      if (i == 3) begin
        for (int g = 0; g < 2; g++) begin
          data_valid_i = 1'b0;
          trigger_i    = 32'hFFFF_FFFF;
          tick();
          vectors++;
          if (bram_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_stall got we=%b, required 0", bram_we_o);
          end
        end
        trigger_i = '0;
      end
      if (i == 5 || i == 8) begin
        vectors++;
        if (status_o.trg_event !== 1'b0 || done_o !== 1'b0) begin
          miscompares++;
          $display("FAIL hit_early_w%0d got trg_event=%b done=%b, required 0 0",
                   i, status_o.trg_event, done_o);
        end
      end
      if (i >= 9) begin
        vectors++;
        if (status_o !== mk_status(5'd1, 5'd9) || done_o !== 1'b1) begin
          miscompares++;
          $display("FAIL hit_fire_w%0d got status=%h done=%b, required status=%h done=1",
                   i, status_o, done_o, mk_status(5'd1, 5'd9));
        end
      end
    end
    test_drained("hit_count");
  endtask

  task automatic test_rearm();
    do_config(1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) put($urandom, (i == 3) ? 32'h0000_0020 : 32'h0, 1'b1, 5'(i));
    vectors++;
    if (status_o !== mk_status(5'd5, 5'd3) || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_first got status=%h done=%b, required status=%h done=1",
               status_o, done_o, mk_status(5'd5, 5'd3));
    end
    // Word presented during the DONE cycle must not be written.
    put($urandom, 32'h1, 1'b0, 5'd0);
    vectors++;
    if (status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_clear got status=%h done=%b, required status=%h done=0",
               status_o, done_o, STATUS_DEFAULT);
    end
    for (int i = 4; i <= 10; i++) put($urandom, (i == 10) ? 32'h8000_0000 : 32'h0, 1'b1, 5'(i));
    vectors++;
    if (status_o !== mk_status(5'd31, 5'd10) || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_second got status=%h done=%b, required status=%h done=1",
               status_o, done_o, mk_status(5'd31, 5'd10));
    end
    tick();
    vectors++;
    if (status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_pulse got status=%h done=%b, required status=%h done=0",
               status_o, done_o, STATUS_DEFAULT);
    end
    test_drained("rearm");
  endtask

  task automatic test_reset_mid();
    do_config(1'b0, 2'd0, 2'd1);
    for (int i = 0; i < 6; i++) put($urandom, (i == 2) ? 32'h4 : 32'h0, 1'b1, 5'(i));
    data_i       = $urandom;
    trigger_i    = 32'h0;
    data_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bram_we_o !== 1'b0 || bram_addr_o !== 5'd0 || bram_data_o !== 32'd0 ||
        status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got we=%b addr=%0d data=%h status=%h done=%b, required all 0",
               bram_we_o, bram_addr_o, bram_data_o, status_o, done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    put($urandom, 32'h1, 1'b0, 5'd0);
    do_config(1'b0, 2'd0, 2'd0);
    put($urandom, 32'h0, 1'b1, 5'd0);
    put($urandom, 32'h1, 1'b1, 5'd1);
    vectors++;
    if (status_o !== mk_status(5'd0, 5'd1) || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_fire got status=%h done=%b, required status=%h done=1",
               status_o, done_o, mk_status(5'd0, 5'd1));
    end
    do_config(1'b0, 2'd0, 2'd0);
    put($urandom, 32'h0, 1'b1, 5'd0);
    vectors++;
    if (status_o !== STATUS_DEFAULT || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_restart got status=%h done=%b, required status=%h done=0",
               status_o, done_o, STATUS_DEFAULT);
    end
    tick();
    test_drained("reset_mid");
  endtask

  initial begin
    rst_n         = 1'b0;
    conf_i        = CONFIG_DEFAULT;
    conf_update_i = 1'b0;
    data_i        = '0;
    data_valid_i  = 1'b0;
    trigger_i     = '0;
    test_reset();
    test_single_shot();
    test_post_wrap();
    test_hit_count();
    test_rearm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
